// File: rtl/data_send_pkg.sv
// Shared definitions for the packet builder / data_send pair: packet type
// codes, frame constants, FSM encoding and the btype -> payload length decode.
package data_send_pkg;

  localparam int         PKT_DATA_LEN = 64;
  localparam int         PKT_CHIP_NUM = 8;
  localparam logic [7:0] PKT_SYNC0    = 8'h55;
  localparam logic [7:0] PKT_SYNC1    = 8'hAA;

  localparam logic [3:0] BAG_DLINK = 4'b1000;
  localparam logic [3:0] BAG_DTYPE = 4'b1001;
  localparam logic [3:0] BAG_DTEMP = 4'b1010;
  localparam logic [3:0] BAG_DATA0 = 4'b1101;
  localparam logic [3:0] BAG_DATA1 = 4'b1110;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_WAIT  = 4'd1,
    ST_SYNC0 = 4'd2,
    ST_SYNC1 = 4'd3,
    ST_LENH  = 4'd4,
    ST_LENL  = 4'd5,
    ST_LOAD  = 4'd6,
    ST_CHK   = 4'd7,
    ST_DONE  = 4'd8
  } ds_state_e;

  // Payload byte count for a packet type; zero marks an unknown type.
  function automatic logic [15:0] bag_len(input logic [3:0] btype,
                                          input int         data_len,
                                          input int         chip_num);
    logic [15:0] len;
    case (btype)
      BAG_DLINK, BAG_DTYPE, BAG_DTEMP: len = 16'd2;
      BAG_DATA0, BAG_DATA1:            len = 16'(2 + chip_num * data_len);
      default:                         len = 16'd0;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/data_send_buf.sv
// Two-entry byte buffer between the packet RAM read port and the tx stream.
// When empty, the incoming byte falls straight through to dout so a RAM
// return can be handed to the sink in the same cycle it arrives.
module data_send_buf
  import data_send_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic [7:0] din,
  input  logic       pop,
  output logic [7:0] dout,
  output logic [1:0] count,
  output logic [1:0] count_nxt
);

  logic [7:0] mem_q [2];
  logic       wr_ptr_q;
  logic       rd_ptr_q;
  logic [1:0] count_q;
  logic       bypass;
  logic       wr_en;
  logic       rd_en;

  assign bypass    = (count_q == 2'd0) && push && pop;
  assign wr_en     = push && !bypass;
  assign rd_en     = pop && (count_q != 2'd0);
  assign count_nxt = count_q + {1'b0, wr_en} - {1'b0, rd_en};
  assign count     = count_q;
  assign dout      = (count_q == 2'd0) ? din : mem_q[rd_ptr_q];

  // Storage, pointers and occupancy; a bypassed byte never touches storage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_q[0] <= 8'h00;
      mem_q[1] <= 8'h00;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (wr_en) begin
        mem_q[wr_ptr_q] <= din;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (rd_en) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_nxt;
    end
  end

endmodule

// File: rtl/data_send.sv
// data_send: reads a finished packet out of the packet RAM and emits it as
// SYNC0 SYNC1 len[15:8] len[7:0] payload chk on a valid/ready byte stream.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | post-reset, moves to WAIT
// WAIT  | waiting for fs; samples btype / ram_addr_init
// SYNC0 | sending first sync byte
// SYNC1 | sending second sync byte
// LENH  | sending len[15:8]
// LENL  | sending len[7:0]; first payload read goes out here
// LOAD  | streaming payload bytes out of the buffer
// CHK   | sending XOR checksum
// DONE  | fd high until the controller drops fs
module data_send
  import data_send_pkg::*;
#(
  parameter int         ADDR_W   = 12,
  parameter int         DATA_LEN = PKT_DATA_LEN,
  parameter int         CHIP_NUM = PKT_CHIP_NUM,
  parameter logic [7:0] SYNC0    = PKT_SYNC0,
  parameter logic [7:0] SYNC1    = PKT_SYNC1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fs,
  output logic              fd,
  input  logic [3:0]        btype,
  input  logic [ADDR_W-1:0] ram_addr_init,
  output logic [ADDR_W-1:0] ram_rxa,
  output logic              ram_rxen,
  input  logic [7:0]        ram_rxd,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready
);

  ds_state_e         state_q;
  ds_state_e         state_d;
  logic [15:0]       len_q;
  logic [15:0]       rd_left_q;
  logic [15:0]       tx_left_q;
  logic [7:0]        chk_q;
  logic [ADDR_W-1:0] addr_q;
  logic              rd_pend_q;
  logic              tx_valid_q;
  logic              tx_valid_d;
  logic              start;
  logic              hs;
  logic              issue;
  logic              buf_pop;
  logic [7:0]        buf_dout;
  logic [1:0]        buf_cnt;
  logic [1:0]        buf_cnt_nxt;
  logic [15:0]       btype_len;

  assign btype_len = bag_len(btype, DATA_LEN, CHIP_NUM);
  assign hs        = tx_valid_q && tx_ready;
  assign buf_pop   = (state_q == ST_LOAD) && hs;

  // Buffer slots are counted together with the read in flight so a return
  // always has somewhere to land.
  assign issue = ((state_q == ST_LENL) || (state_q == ST_LOAD)) &&
                 ((buf_cnt + {1'b0, rd_pend_q}) < 2'd2) &&
                 (rd_left_q != 16'd0);

  assign ram_rxen = issue;
  assign ram_rxa  = addr_q;
  assign tx_valid = tx_valid_q;
  assign fd       = (state_q == ST_DONE);

  data_send_buf u_buf (
    .clk       (clk),
    .rst       (rst),
    .push      (rd_pend_q),
    .din       (ram_rxd),
    .pop       (buf_pop),
    .dout      (buf_dout),
    .count     (buf_cnt),
    .count_nxt (buf_cnt_nxt)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, frame start strobe and next-cycle tx_valid.
  always_comb begin
    state_d    = state_q;
    start      = 1'b0;
    tx_valid_d = 1'b0;
    case (state_q)
      ST_IDLE:  state_d = ST_WAIT;
      ST_WAIT: begin
        if (fs) begin
          if (btype_len != 16'd0) begin
            state_d = ST_SYNC0;
            start   = 1'b1;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_SYNC0: if (hs) state_d = ST_SYNC1;
      ST_SYNC1: if (hs) state_d = ST_LENH;
      ST_LENH:  if (hs) state_d = ST_LENL;
      ST_LENL:  if (hs) state_d = ST_LOAD;
      ST_LOAD:  if (hs && (tx_left_q == 16'd1)) state_d = ST_CHK;
      ST_CHK:   if (hs) state_d = ST_DONE;
      ST_DONE:  if (!fs) state_d = ST_WAIT;
      default:  state_d = ST_IDLE;
    endcase

    case (state_d)
      ST_SYNC0, ST_SYNC1, ST_LENH, ST_LENL, ST_CHK: tx_valid_d = 1'b1;
      ST_LOAD: tx_valid_d = (buf_cnt_nxt != 2'd0) || issue;
      default: tx_valid_d = 1'b0;
    endcase
  end

  // Outgoing byte selected by state; payload comes from the buffer head.
  always_comb begin
    tx_data = 8'h00;
    case (state_q)
      ST_SYNC0: tx_data = SYNC0;
      ST_SYNC1: tx_data = SYNC1;
      ST_LENH:  tx_data = len_q[15:8];
      ST_LENL:  tx_data = len_q[7:0];
      ST_LOAD:  tx_data = tx_valid_q ? buf_dout : 8'h00;
      ST_CHK:   tx_data = chk_q;
      default:  tx_data = 8'h00;
    endcase
  end

  // Frame datapath: length, read/send down-counters, address and checksum.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      len_q      <= 16'd0;
      rd_left_q  <= 16'd0;
      tx_left_q  <= 16'd0;
      chk_q      <= 8'h00;
      addr_q     <= '0;
      rd_pend_q  <= 1'b0;
      tx_valid_q <= 1'b0;
    end else begin
      tx_valid_q <= tx_valid_d;
      rd_pend_q  <= issue;
      if (start) begin
        len_q     <= btype_len;
        rd_left_q <= btype_len;
        tx_left_q <= btype_len;
        addr_q    <= ram_addr_init;
        chk_q     <= 8'h00;
      end else begin
        if (issue) begin
          addr_q    <= addr_q + ADDR_W'(1);
          rd_left_q <= rd_left_q - 16'd1;
        end
        if (hs && ((state_q == ST_LENH) || (state_q == ST_LENL) ||
                   (state_q == ST_LOAD))) begin
          chk_q <= chk_q ^ tx_data;
        end
        if (buf_pop) begin
          tx_left_q <= tx_left_q - 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_data_send.sv
// Directed bench for data_send: RAM model, stream monitor and frame checks.
`timescale 1ns/1ps
module tb_data_send;
  import data_send_pkg::*;

  localparam int ADDR_W = 12;

  logic              clk;
  logic              rst;
  logic              fs;
  logic              fd;
  logic [3:0]        btype;
  logic [ADDR_W-1:0] ram_addr_init;
  logic [ADDR_W-1:0] ram_rxa;
  logic              ram_rxen;
  logic [7:0]        ram_rxd;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready;

  logic [7:0]        mem [4096];

  int n_vec;
  int n_err;

  // monitor-owned state
  int                cyc;
  int                mon_id;
  int                rxen_cnt;
  int                valid_cnt;
  int                stab_err;
  int                ovf_err;
  int                fd_rise;
  int                pops;
  logic              prev_stall;
  logic              prev_fd;
  logic [7:0]        prev_data;
  logic [7:0]        rx_q[$];
  int                hs_cyc[$];
  logic [ADDR_W-1:0] rd_addr_q[$];

  // stimulus-owned state
  int                frame_id;
  int                start_cyc;
  logic              rnd_ready;
  logic [7:0]        exp_q[$];

  data_send #(.ADDR_W(ADDR_W)) u_dut (
    .clk           (clk),
    .rst           (rst),
    .fs            (fs),
    .fd            (fd),
    .btype         (btype),
    .ram_addr_init (ram_addr_init),
    .ram_rxa       (ram_rxa),
    .ram_rxen      (ram_rxen),
    .ram_rxd       (ram_rxd),
    .tx_data       (tx_data),
    .tx_valid      (tx_valid),
    .tx_ready      (tx_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // synchronous packet RAM: data valid the cycle after the read enable
  always @(posedge clk) begin
    if (ram_rxen) ram_rxd <= mem[ram_rxa];
  end

  // sink ready: held high or 50% random
  initial begin
    tx_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      tx_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // stream monitor, sampled mid-cycle
  initial begin
    cyc = 0; mon_id = 0; rxen_cnt = 0; valid_cnt = 0; stab_err = 0; ovf_err = 0;
    fd_rise = -1; prev_stall = 1'b0; prev_fd = 1'b0; prev_data = 8'h00;
    forever begin
      @(negedge clk);
      cyc++;
      if (frame_id != mon_id) begin
        mon_id = frame_id;
        rx_q.delete(); hs_cyc.delete(); rd_addr_q.delete();
        rxen_cnt = 0; valid_cnt = 0; fd_rise = -1;
      end
      if (rst) begin
        if (prev_stall && (!tx_valid || tx_data != prev_data)) stab_err++;
        if (tx_valid) valid_cnt++;
        if (ram_rxen) begin
          rxen_cnt++;
          rd_addr_q.push_back(ram_rxa);
        end
        if (tx_valid && tx_ready) begin
          rx_q.push_back(tx_data);
          hs_cyc.push_back(cyc);
        end
        if (fd && !prev_fd) fd_rise = cyc;
        pops = (rx_q.size() > 4) ? rx_q.size() - 4 : 0;
        if (rxen_cnt - pops > 2) ovf_err++;
        prev_stall = tx_valid && !tx_ready;
        prev_data  = tx_data;
        prev_fd    = fd;
      end else begin
        prev_stall = 1'b0;
        prev_fd    = 1'b0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required $finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic run_frame(input logic [3:0] bt, input logic [ADDR_W-1:0] a, input int budget);
    int n;
    @(posedge clk);
    #1;
    frame_id++;
    btype         = bt;
    ram_addr_init = a;
    fs            = 1'b1;
    start_cyc     = cyc;
    n = 0;
    while (!fd && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("fd_seen", 32'(fd), 32'd1);
    @(posedge clk);
    #1;
    fs = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("fd_clear", 32'(fd), 32'd0);
  endtask

  task automatic build_exp(input logic [ADDR_W-1:0] a, input int len);
    logic [7:0] c;
    logic [7:0] b;
    logic [15:0] l;
    l = 16'(len);
    exp_q.delete();
    exp_q.push_back(8'h55);
    exp_q.push_back(8'hAA);
    exp_q.push_back(l[15:8]);
    exp_q.push_back(l[7:0]);
    c = l[15:8] ^ l[7:0];
    for (int i = 0; i < len; i++) begin
      b = mem[12'(a + ADDR_W'(i))];
      exp_q.push_back(b);
      c = c ^ b;
    end
    exp_q.push_back(c);
  endtask

  task automatic cmp_frame(input string tag);
    check({tag, "_nbytes"}, rx_q.size(), exp_q.size());
    foreach (exp_q[i]) begin
      if (i < rx_q.size())
        check($sformatf("%s_b%0d", tag, i), 32'(rx_q[i]), 32'(exp_q[i]));
    end
  endtask

  task automatic fill_mem();
    for (int i = 0; i < 4096; i++) mem[i] = 8'(i);
  endtask

  initial begin
    n_vec = 0; n_err = 0; frame_id = 0; rnd_ready = 1'b0;
    rst = 1'b1; fs = 1'b0; btype = 4'h0; ram_addr_init = '0;
    fill_mem();
    #2 rst = 1'b0;
    #1;
    check("rst_fd", 32'(fd), 32'd0);
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_rxen", 32'(ram_rxen), 32'd0);
    check("rst_rxa", 32'(ram_rxa), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);

    // short DTYPE frame, back to back
    mem[12'h100] = 8'h13;
    mem[12'h101] = 8'h2A;
    run_frame(BAG_DTYPE, 12'h100, 100);
    exp_q = '{8'h55, 8'hAA, 8'h00, 8'h02, 8'h13, 8'h2A, 8'h3B};
    cmp_frame("dtype");
    check("dtype_rxen", rxen_cnt, 2);
    if (hs_cyc.size() == 7) begin
      check("dtype_contig", hs_cyc[6] - hs_cyc[0], 6);
      check("dtype_fd_lat", fd_rise - hs_cyc[6], 1);
    end else begin
      check("dtype_hs", hs_cyc.size(), 7);
    end
    if (rd_addr_q.size() > 0) check("dtype_addr0", 32'(rd_addr_q[0]), 32'h100);

    // full DATA0 frame, ready held high
    fill_mem();
    run_frame(BAG_DATA0, 12'h000, 3000);
    build_exp(12'h000, 514);
    cmp_frame("data0");
    check("data0_rxen", rxen_cnt, 514);
    if (rx_q.size() == 519) begin
      check("data0_lenh", 32'(rx_q[2]), 32'h02);
      check("data0_lenl", 32'(rx_q[3]), 32'h02);
      check("data0_chk", 32'(rx_q[518]), 32'h01);
      check("data0_contig", hs_cyc[518] - hs_cyc[0], 518);
    end

    // same frame against a stalling sink
    rnd_ready = 1'b1;
    run_frame(BAG_DATA0, 12'h000, 6000);
    cmp_frame("data0_rnd");
    check("data0_rnd_rxen", rxen_cnt, 514);
    rnd_ready = 1'b0;

    // unknown btype: straight to DONE, nothing emitted
    run_frame(4'b0000, 12'h000, 10);
    check("inv_valid", valid_cnt, 0);
    check("inv_rxen", rxen_cnt, 0);
    check("inv_fd_lat", 32'((fd_rise - start_cyc) >= 1 && (fd_rise - start_cyc) <= 2), 32'd1);

    // address wrap
    mem[12'hFFF] = 8'hC3;
    mem[12'h000] = 8'h5A;
    run_frame(BAG_DLINK, 12'hFFF, 100);
    exp_q = '{8'h55, 8'hAA, 8'h00, 8'h02, 8'hC3, 8'h5A, 8'h9B};
    cmp_frame("wrap");
    check("wrap_rxen", rxen_cnt, 2);
    if (rd_addr_q.size() == 2) begin
      check("wrap_addr0", 32'(rd_addr_q[0]), 32'hFFF);
      check("wrap_addr1", 32'(rd_addr_q[1]), 32'h000);
    end

    // reset in the middle of a DATA1 payload
    fill_mem();
    @(posedge clk);
    #1;
    frame_id++;
    btype = BAG_DATA1; ram_addr_init = 12'h000; fs = 1'b1;
    for (int n = 0; n < 100 && rx_q.size() < 10; n++) @(negedge clk);
    check("pre_rst_bytes", 32'(rx_q.size() >= 10), 32'd1);
    check("pre_rst_valid", 32'(tx_valid), 32'd1);
    check("pre_rst_rxen", 32'(ram_rxen), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("abort_valid", 32'(tx_valid), 32'd0);
    check("abort_rxen", 32'(ram_rxen), 32'd0);
    check("abort_fd", 32'(fd), 32'd0);
    mem[12'h200] = 8'h81;
    mem[12'h201] = 8'h7E;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    run_frame(BAG_DTEMP, 12'h200, 100);
    exp_q = '{8'h55, 8'hAA, 8'h00, 8'h02, 8'h81, 8'h7E, 8'hFD};
    cmp_frame("post_rst");

    check("stable_hold", stab_err, 0);
    check("no_overflow", ovf_err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/data_send.md
Name: data_send

Overview:
- Downstream neighbour of the packet builder. Once the builder reports a packet complete in the shared packet RAM, this block reads the packet out byte by byte.
- Each packet is framed as: two sync bytes, a 16-bit length, the payload, then an XOR checksum.
- Frames leave on a valid/ready byte stream toward the host link (USB/UART bridge).
- Handshake with the top-level controller is the codebase's fs/fd level pair.

Parameters:
- ADDR_W, 12, packet RAM address width
- DATA_LEN, 64, bytes per ADC chip per data packet
- CHIP_NUM, 8, ADC chips per data packet
- SYNC0, 8'h55, first frame sync byte
- SYNC1, 8'hAA, second frame sync byte

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- fs  in  1  start request (level); held by controller until fd seen
- fd  out  1  done; high while in DONE
- btype  in  4  packet type, sampled in WAIT when fs=1
- ram_addr_init  in  ADDR_W  first payload byte address, sampled with btype
- ram_rxa  out  ADDR_W  RAM read address
- ram_rxen  out  1  RAM read enable
- ram_rxd  in  8  RAM read data, valid exactly 1 cycle after ram_rxen
- tx_data  out  8  stream byte
- tx_valid  out  1  stream byte valid
- tx_ready  in  1  sink accepts byte when tx_valid & tx_ready

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, fd=0, ram_rxa=0, ram_rxen=0, tx_data=0, tx_valid=0, all counters/checksum/buffer cleared. Reset mid-frame aborts immediately; no partial-frame resume.
- Payload length (16-bit), decoded from btype:
  - 4'b1000 DLINK, 4'b1001 DTYPE, 4'b1010 DTEMP: 2.
  - 4'b1101 DATA0, 4'b1110 DATA1: 2+CHIP_NUM*DATA_LEN = 514.
  - Any other btype: 0.
- FSM states: IDLE, WAIT, SYNC0, SYNC1, LENH, LENL, LOAD, CHK, DONE.
- Transitions:
  - IDLE->WAIT unconditionally.
  - WAIT->SYNC0 on fs with a valid btype. WAIT->DONE on fs with an unknown btype: no bytes emitted.
  - SYNC0, SYNC1, LENH, LENL each advance on a tx handshake.
  - LENL->LOAD on handshake.
  - LOAD->CHK when the last payload byte is handshaken.
  - CHK->DONE on handshake.
  - DONE->WAIT when fs=0. fs falling mid-frame is ignored; the frame completes.
- Bytes emitted in order: SYNC0, SYNC1, len[15:8], len[7:0], payload, chk.
  - chk = XOR of len[15:8], len[7:0] and every payload byte.
  - chk register resets to 0 on WAIT->SYNC0.
- Stream rules:
  - tx_valid, once high, stays high with tx_data stable until handshake.
  - tx_valid is registered; tx_data never depends combinationally on tx_ready.
- Payload read pipeline (LOAD):
  - 2-entry byte buffer feeds tx_data. A read is issued (ram_rxen=1, ram_rxa=next address) when occupancy + reads in flight < 2 and reads issued < len.
  - Returned ram_rxd is written into the buffer on the following cycle.
  - Sustained throughput is 1 byte/clk with tx_ready held high.
  - First payload read issues in the LENL cycle, so no bubble between len[7:0] and payload byte 0.
- Addressing: ram_rxa starts at ram_addr_init and increments by 1 per issued read, modulo 2^ADDR_W (wrap 12'hFFF->12'h000 permitted).
- Simultaneous push (RAM return) and pop (handshake) on the buffer in the same cycle are both honoured; occupancy is unchanged.
- Frame length on the wire is len+5 bytes. A full DATA frame is 519 bytes.
- ram_rxen=0 outside LOAD/LENL. The block never reads beyond len bytes.

Decomposition:
- Shared package holds: BAG_* btype codes, DATA_LEN, CHIP_NUM, SYNC0/SYNC1, FSM state encodings, and the btype->length decode function, shared with the packet builder.
- One natural sub-module: data_send_buf, the 2-entry byte skid buffer with push/pop/count.

Test Plan:
- DTYPE, ram_addr_init=12'h100, RAM[100]=8'h13, RAM[101]=8'h2A, tx_ready=1 -> stream 55 AA 00 02 13 2A 3B, 7 back-to-back bytes; fd rises the cycle after chk handshake.
- DATA0 with RAM[a]=a[7:0], tx_ready=1 -> 519 contiguous bytes; len field 02 02; chk equals XOR of all 514 payload bytes and 02,02; exactly 514 ram_rxen pulses.
- DATA0, tx_ready random 50% -> identical byte sequence to the previous case; tx_data never changes while tx_valid=1 and tx_ready=0; buffer never overflows.
- btype=4'b0000 with fs=1 -> no tx_valid, no ram_rxen; fd=1 within 2 cycles; fs low -> returns to WAIT and fd=0.
- ram_addr_init=12'hFFF, DLINK -> reads 12'hFFF then 12'h000; payload order preserved.
- rst low during LOAD of DATA1 -> tx_valid, ram_rxen, fd drop asynchronously. After release with fs=1/DTEMP, a clean frame 55 AA 00 02 ... is sent with chk computed fresh.
